// File: rtl/twos_to_signmag_norm.sv
// Two's-complement to sign-magnitude converter with optional left-shift normalization.
// Define NORMALIZE_EN to build the NORM state; otherwise the raw magnitude is passed through.
module twos_to_signmag_norm (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic [7:0]   in_exp,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sign,
  output logic [7:0]   out_mag,
  output logic [7:0]   out_exp,
  output logic         out_zero,
  output logic         out_uflow
);

  localparam int unsigned W = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NEG  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
`ifdef NORMALIZE_EN
  localparam logic [1:0] NORM = 2'd3;
`endif

  logic [1:0]   state, state_n;
  logic         sign_n, zero_n, uflow_n, valid_n;
  logic [W-1:0] mag_n, exp_n;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and next values of every registered output
  always_comb begin
    state_n = state;
    sign_n  = out_sign;
    mag_n   = out_mag;
    exp_n   = out_exp;
    zero_n  = out_zero;
    uflow_n = out_uflow;
    valid_n = out_valid;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_n  = in_data[W-1];
          mag_n   = in_data;
          exp_n   = in_exp;
          zero_n  = 1'b0;
          uflow_n = 1'b0;
          state_n = NEG;
        end
      end
      NEG: begin
        // 0x80 negates to itself, which is the correct unsigned 128
        mag_n  = out_sign ? W'(~out_mag + W'(1)) : out_mag;
        zero_n = (mag_n == '0);
`ifdef NORMALIZE_EN
        state_n = NORM;
`else
        state_n = DONE;
`endif
      end
`ifdef NORMALIZE_EN
      NORM: begin
        if (out_mag == '0) begin
          zero_n  = 1'b1;
          exp_n   = '0;
          state_n = DONE;
        end else if (out_mag[W-1]) begin
          state_n = DONE;
        end else if (out_exp == '0) begin
          uflow_n = 1'b1;
          state_n = DONE;
        end else begin
          mag_n = {out_mag[W-2:0], 1'b0};
          exp_n = out_exp - W'(1);
        end
      end
`endif
      DONE: begin
        // out_valid rises one edge after entering DONE; handshake only once it is up
        if (out_valid && out_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end else begin
          valid_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_mag   <= '0;
      out_exp   <= '0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
    end else begin
      in_ready  <= (state_n == IDLE);
      out_valid <= valid_n;
      out_sign  <= sign_n;
      out_mag   <= mag_n;
      out_exp   <= exp_n;
      out_zero  <= zero_n;
      out_uflow <= uflow_n;
    end
  end

endmodule
